pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed 32-bit IF/ID latch. It carries a DATA_W payload plus a PC_W program counter between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a valid/ready handshake and a one-entry skid buffer, so backpressure never drops or duplicates an instruction. It keeps the global hazard stall, memory stall and flush controls, and optionally counts stall and flush events.

## Interface
Parameters:
- DATA_W, 32, payload width (instruction word or packed control/data bundle)
- PC_W, 32, program-counter width
- FLUSH_VAL, {DATA_W{1'b0}}, payload value loaded on flush and reset (bubble/NOP)
- CNT_W, 16, width of performance counters

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- valid_i  in  1  upstream entry valid
- data_i  in  DATA_W  upstream payload
- pc_i  in  PC_W  upstream PC
- ready_o  out  1  stage can accept this cycle
- valid_o  out  1  output entry valid
- data_o  out  DATA_W  output payload
- pc_o  out  PC_W  output PC
- ready_i  in  1  downstream accepts this cycle
- Stall_i  in  1  hazard-unit stall (freeze)
- MemStall_i  in  1  memory stall (freeze)
- Flush_i  in  1  discard all held entries
- stall_cnt_o  out  CNT_W  frozen-cycle count
- flush_cnt_o  out  CNT_W  flush count

## Operation
- Storage: main register (valid_q, data_q, pc_q) drives the outputs. Skid register (skid_v, skid_data, skid_pc) is hidden.
- freeze = Stall_i | MemStall_i.
- ready_o = !skid_v & !freeze & !Flush_i. This path is combinational.
- valid_o = valid_q & !freeze. data_o = data_q and pc_o = pc_q at all times.
- in_fire = valid_i & ready_o. out_fire = valid_o & ready_i.
- Priority per edge, highest first:
  - Reset: valid_q=0, skid_v=0, data_q=FLUSH_VAL, pc_q=0, skid_data=FLUSH_VAL, skid_pc=0, counters=0.
  - Flush_i: valid_q=0, skid_v=0, data_q=FLUSH_VAL, pc_q held. Flush wins over freeze, so a flush is never lost during a stall.
  - freeze: all state held, nothing accepted or consumed.
  - Normal operation:
    - If !valid_q or out_fire, main loads from skid when skid_v (then skid_v=0). Otherwise it loads from input when in_fire. Otherwise valid_q=0 and data_q/pc_q hold.
    - If valid_q and !out_fire and in_fire, the input is written to skid and skid_v=1.
- Order is preserved. The skid entry always leaves before any newer input.
- Skid is only ever written while ready_o=1, so it cannot overflow.

## Timing
- Latency: 1 cycle from in_fire to valid_o when the stage is empty.
- Throughput: 1 entry/cycle while ready_i=1.
- Backpressure:
  - When ready_i drops with a full main register, one more entry is absorbed into skid.
  - ready_o falls in the following cycle.
  - ready_o returns in the cycle after the skid entry moves into main.
- Freeze: outputs hold their registered values, and valid_o reads 0 for every frozen cycle. Operation resumes on the first unfrozen edge with no loss.
- Flush is a 1-cycle pulse: valid_o=0 from the next cycle. The input presented in the flush cycle is not accepted (ready_o=0).
- Reset mid-transfer: any in-flight main and skid entries are discarded, and ready_o=1 on the first cycle after reset release.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - stall_cnt_o increments on every edge with freeze=1 (reset excluded).
  - flush_cnt_o increments on every edge with Flush_i=1.
  - Both saturate at all-ones and clear only on reset.
- Undefined: no counter logic is generated, and stall_cnt_o/flush_cnt_o are tied to 0.

## Test plan
- Streaming: reset low 2 cycles; drive data 0x00000013, 0x00100093, 0x00200113 with pc 0x0,0x4,0x8, valid_i=1, ready_i=1 -> valid_o high from cycle 1, same sequence out one cycle later, ready_o constant 1.
- Backpressure: main holds pc 0x4, ready_i=0, valid_i=1 pc 0x8 -> pc 0x8 goes to skid, ready_o=0 next cycle. Release ready_i -> outputs pc 0x4 then 0x8, no drop or duplicate, ready_o=1 again after 0x8 reaches main.
- Freeze: MemStall_i=1 for 3 cycles with valid_q=1 pc 0x10 -> valid_o=0, pc_o=0x10 held, ready_o=0. With PIPE_STAGE_PERF_EN, stall_cnt_o=3 afterward. Next entry appears one cycle after release.
- Flush over stall: skid and main full, Stall_i=1 and Flush_i=1 same edge -> valid_o=0, data_o=FLUSH_VAL, skid empty, ready_o=1 next cycle, flush_cnt_o=1 (macro on) / 0 (macro off).
- Reset mid-operation: main and skid full, rst_i=0 one edge -> valid_o=0, pc_o=0, data_o=FLUSH_VAL, counters 0. Param sweep DATA_W=64, PC_W=16 repeats scenario 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Parametrised CPU pipeline stage register. It carries a payload and a PC
//   from one stage to the next. A valid/ready handshake and a one-entry skid
//   buffer make sure that backpressure never drops or duplicates an entry.
//   The global hazard stall and memory stall freeze the stage. The flush
//   control discards every entry held in the stage.
//
//   Optional feature: define PIPE_STAGE_PERF_EN to build saturating counters
//   for frozen cycles and flushes. If it is undefined, both counters read 0.
//
// Parameters
//   DATA_W     payload width
//   PC_W       program-counter width
//   FLUSH_VAL  payload loaded on flush and on reset (bubble / NOP)
//   CNT_W      performance counter width
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-low
//   valid_i      upstream entry valid
//   data_i       upstream payload
//   pc_i         upstream PC
//   ready_o      stage can accept this cycle (combinational)
//   valid_o      output entry valid (forced low while frozen)
//   data_o       output payload
//   pc_o         output PC
//   ready_i      downstream accepts this cycle
//   Stall_i      hazard-unit stall (freeze)
//   MemStall_i   memory stall (freeze)
//   Flush_i      discard all held entries
//   stall_cnt_o  frozen-cycle count
//   flush_cnt_o  flush count
module pipe_stage_reg #(
  parameter int                 DATA_W    = 32,
  parameter int                 PC_W      = 32,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [PC_W-1:0]   pc_o,
  input  logic              ready_i,
  input  logic              Stall_i,
  input  logic              MemStall_i,
  input  logic              Flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [PC_W-1:0]   pc_p1;
  logic              skid_vld_p1;
  logic [DATA_W-1:0] skid_data_p1;
  logic [PC_W-1:0]   skid_pc_p1;

  logic freeze;
  logic in_fire;
  logic out_fire;

  assign freeze   = Stall_i | MemStall_i;
  assign ready_o  = ~skid_vld_p1 & ~freeze & ~Flush_i;
  assign valid_o  = vld_p1 & ~freeze;
  assign data_o   = data_p1;
  assign pc_o     = pc_p1;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // ---- stage boundary: input -> main / skid registers ----
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_p1       <= 1'b0;
      data_p1      <= FLUSH_VAL;
      pc_p1        <= '0;
      skid_vld_p1  <= 1'b0;
      skid_data_p1 <= FLUSH_VAL;
      skid_pc_p1   <= '0;
    end else if (Flush_i) begin
      // The flush is checked before freeze, so a flush raised during a stall still takes effect.
      vld_p1      <= 1'b0;
      data_p1     <= FLUSH_VAL;
      skid_vld_p1 <= 1'b0;
    end else if (!freeze) begin
      if (!vld_p1 || out_fire) begin
        // The skid entry is older than any input, so it drains first.
        // ready_o is low whenever skid is full, so no input is lost here.
        if (skid_vld_p1) begin
          vld_p1      <= 1'b1;
          data_p1     <= skid_data_p1;
          pc_p1       <= skid_pc_p1;
          skid_vld_p1 <= 1'b0;
        end else if (in_fire) begin
          vld_p1  <= 1'b1;
          data_p1 <= data_i;
          pc_p1   <= pc_i;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (in_fire) begin
        skid_vld_p1  <= 1'b1;
        skid_data_p1 <= data_i;
        skid_pc_p1   <= pc_i;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] stall_cnt_p1;
  logic [CNT_W-1:0] flush_cnt_p1;

  // ---- stage boundary: event counters ----
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_p1 <= '0;
      flush_cnt_p1 <= '0;
    end else begin
      if (freeze)  stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (Flush_i) flush_cnt_p1 <= sat_inc(flush_cnt_p1);
    end
  end

  assign stall_cnt_o = stall_cnt_p1;
  assign flush_cnt_o = flush_cnt_p1;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam logic [31:0] FV = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_i, stall, memstall, flush;
  logic [31:0] data_i, pc_i;
  logic        ready_o, valid_o;
  logic [31:0] data_o, pc_o;
  logic [15:0] stall_cnt, flush_cnt;

  logic        v64_i, r64_i, rdy64_o, v64_o;
  logic [63:0] d64_i, d64_o;
  logic [15:0] p64_i, p64_o;
  logic [15:0] sc64, fc64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .PC_W(32), .FLUSH_VAL(FV), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .data_i(data_i), .pc_i(pc_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .pc_o(pc_o),
    .ready_i(ready_i), .Stall_i(stall), .MemStall_i(memstall), .Flush_i(flush),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .PC_W(16)) dut64 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(v64_i), .data_i(d64_i), .pc_i(p64_i),
    .ready_o(rdy64_o), .valid_o(v64_o), .data_o(d64_o), .pc_o(p64_o),
    .ready_i(r64_i), .Stall_i(1'b0), .MemStall_i(1'b0), .Flush_i(1'b0),
    .stall_cnt_o(sc64), .flush_cnt_o(fc64)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after new inputs are driven.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] p);
    valid_i = v;
    data_i  = d;
    pc_i    = p;
  endtask

  logic [15:0] exp_stall, exp_flush;

  initial begin
    rst_n = 1'b0; ready_i = 1'b1; stall = 1'b0; memstall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    v64_i = 1'b0; r64_i = 1'b1; d64_i = '0; p64_i = '0;

    // ---------------- Streaming ----------------
    tick(); tick();
    settle();
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_pc", {32'd0, pc_o}, 64'd0);
    chk("rst_data", {32'd0, data_o}, {32'd0, FV});
    chk("rst_stallcnt", {48'd0, stall_cnt}, 64'd0);
    chk("rst_flushcnt", {48'd0, flush_cnt}, 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 32'h0000_0013, 32'h0);
    settle();
    chk("s1_rdy0", {63'd0, ready_o}, 64'd1);
    chk("s1_vld0", {63'd0, valid_o}, 64'd0);
    tick();
    drive(1'b1, 32'h0010_0093, 32'h4);
    settle();
    chk("s1_vld1", {63'd0, valid_o}, 64'd1);
    chk("s1_data1", {32'd0, data_o}, 64'h0000_0013);
    chk("s1_pc1", {32'd0, pc_o}, 64'h0);
    chk("s1_rdy1", {63'd0, ready_o}, 64'd1);
    tick();
    drive(1'b1, 32'h0020_0113, 32'h8);
    settle();
    chk("s1_data2", {32'd0, data_o}, 64'h0010_0093);
    chk("s1_pc2", {32'd0, pc_o}, 64'h4);
    chk("s1_rdy2", {63'd0, ready_o}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    settle();
    chk("s1_data3", {32'd0, data_o}, 64'h0020_0113);
    chk("s1_pc3", {32'd0, pc_o}, 64'h8);
    chk("s1_vld3", {63'd0, valid_o}, 64'd1);
    tick();
    settle();
    chk("s1_drain", {63'd0, valid_o}, 64'd0);

    // ---------------- Backpressure ----------------
    drive(1'b1, 32'hAAAA_0004, 32'h4);
    tick();
    ready_i = 1'b0;
    drive(1'b1, 32'hBBBB_0008, 32'h8);
    settle();
    chk("bp_pc_main", {32'd0, pc_o}, 64'h4);
    chk("bp_rdy_pre", {63'd0, ready_o}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    settle();
    chk("bp_rdy_full", {63'd0, ready_o}, 64'd0);
    chk("bp_pc_hold", {32'd0, pc_o}, 64'h4);
    chk("bp_vld_hold", {63'd0, valid_o}, 64'd1);
    tick();
    settle();
    chk("bp_pc_hold2", {32'd0, pc_o}, 64'h4);
    chk("bp_rdy_full2", {63'd0, ready_o}, 64'd0);
    ready_i = 1'b1;
    settle();
    chk("bp_out_pc4", {32'd0, pc_o}, 64'h4);
    tick();
    settle();
    chk("bp_out_pc8", {32'd0, pc_o}, 64'h8);
    chk("bp_out_data8", {32'd0, data_o}, 64'hBBBB_0008);
    chk("bp_out_vld8", {63'd0, valid_o}, 64'd1);
    chk("bp_rdy_back", {63'd0, ready_o}, 64'd1);
    tick();
    settle();
    chk("bp_no_dup", {63'd0, valid_o}, 64'd0);

    // ---------------- Freeze ----------------
    drive(1'b1, 32'hCCCC_0010, 32'h10);
    tick();
    drive(1'b1, 32'hDDDD_0014, 32'h14);
    memstall = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("fz_vld", {63'd0, valid_o}, 64'd0);
      chk("fz_pc", {32'd0, pc_o}, 64'h10);
      chk("fz_rdy", {63'd0, ready_o}, 64'd0);
      tick();
    end
    memstall = 1'b0;
    settle();
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    chk("fz_stallcnt", {48'd0, stall_cnt}, {48'd0, exp_stall});
    chk("fz_resume_vld", {63'd0, valid_o}, 64'd1);
    chk("fz_resume_pc", {32'd0, pc_o}, 64'h10);
    chk("fz_resume_rdy", {63'd0, ready_o}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    settle();
    chk("fz_next_pc", {32'd0, pc_o}, 64'h14);
    chk("fz_next_data", {32'd0, data_o}, 64'hDDDD_0014);
    tick();

    // ---------------- Flush over stall ----------------
    drive(1'b1, 32'hEEEE_0020, 32'h20);
    tick();
    ready_i = 1'b0;
    drive(1'b1, 32'hEEEE_0024, 32'h24);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    settle();
    chk("fl_full", {63'd0, ready_o}, 64'd0);
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h9999_0028, 32'h28);
    settle();
    chk("fl_rdy_in_flush", {63'd0, ready_o}, 64'd0);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    ready_i = 1'b1;
    settle();
`ifdef PIPE_STAGE_PERF_EN
    exp_flush = 16'd1;
    exp_stall = 16'd4;
`else
    exp_flush = 16'd0;
    exp_stall = 16'd0;
`endif
    chk("fl_vld", {63'd0, valid_o}, 64'd0);
    chk("fl_data", {32'd0, data_o}, {32'd0, FV});
    chk("fl_pc_held", {32'd0, pc_o}, 64'h20);
    chk("fl_rdy", {63'd0, ready_o}, 64'd1);
    chk("fl_flushcnt", {48'd0, flush_cnt}, {48'd0, exp_flush});
    chk("fl_stallcnt", {48'd0, stall_cnt}, {48'd0, exp_stall});
    tick();
    settle();
    chk("fl_skid_gone", {63'd0, valid_o}, 64'd0);

    // ---------------- Reset mid-operation ----------------
    drive(1'b1, 32'h1234_0030, 32'h30);
    tick();
    ready_i = 1'b0;
    drive(1'b1, 32'h1234_0034, 32'h34);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("rm_vld", {63'd0, valid_o}, 64'd0);
    chk("rm_pc", {32'd0, pc_o}, 64'h0);
    chk("rm_data", {32'd0, data_o}, {32'd0, FV});
    chk("rm_rdy", {63'd0, ready_o}, 64'd1);
    chk("rm_stallcnt", {48'd0, stall_cnt}, 64'd0);
    chk("rm_flushcnt", {48'd0, flush_cnt}, 64'd0);
    ready_i = 1'b1;
    tick();
    settle();
    chk("rm_skid_gone", {63'd0, valid_o}, 64'd0);

    // ---------------- Param sweep: DATA_W=64, PC_W=16 ----------------
    rst_n = 1'b0;
    tick(); tick();
    settle();
    chk("w_rst_vld", {63'd0, v64_o}, 64'd0);
    chk("w_rst_data", d64_o, 64'd0);
    rst_n = 1'b1;
    v64_i = 1'b1; d64_i = 64'hF00D_0000_0000_0013; p64_i = 16'h0;
    settle();
    chk("w_rdy0", {63'd0, rdy64_o}, 64'd1);
    tick();
    d64_i = 64'hF00D_0001_0010_0093; p64_i = 16'h4;
    settle();
    chk("w_data1", d64_o, 64'hF00D_0000_0000_0013);
    chk("w_pc1", {48'd0, p64_o}, 64'h0);
    chk("w_vld1", {63'd0, v64_o}, 64'd1);
    tick();
    d64_i = 64'hF00D_0002_0020_0113; p64_i = 16'h8;
    settle();
    chk("w_data2", d64_o, 64'hF00D_0001_0010_0093);
    chk("w_pc2", {48'd0, p64_o}, 64'h4);
    chk("w_rdy2", {63'd0, rdy64_o}, 64'd1);
    tick();
    v64_i = 1'b0;
    settle();
    chk("w_data3", d64_o, 64'hF00D_0002_0020_0113);
    chk("w_pc3", {48'd0, p64_o}, 64'h8);
    tick();
    settle();
    chk("w_drain", {63'd0, v64_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
